pattern_buffer: RTL and testbench
=================================

Name: pattern_buffer

Overview:
- Pattern buffer store that answers the pat core's buffer/field interface: the core drives bufp, fieldp, fieldwp and field_byte_out, and this block returns field_byte_in.
- Holds 2^bufp_width buffers of 2^fieldp_width byte-wide fields.
- A second, independent port streams a selected buffer out serially, MSB first, to the pattern output pin logic under a valid/ready handshake.

Parameters:
- bufp_width, 3, buffer pointer width; number of buffers = 2^bufp_width
- fieldp_width, 5, field pointer width; fields per buffer = 2^fieldp_width
- buffer_width, 8, field (byte) width in bits; also the number of bits shifted out per field

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- bufp  in  bufp_width  buffer select from core, for both read and write
- fieldp  in  fieldp_width  core read field pointer
- fieldwp  in  fieldp_width  core write field pointer
- field_we  in  1  core write enable
- field_byte_out  in  buffer_width  core write data
- field_byte_in  out  buffer_width  core read data, registered
- stream_start  in  1  request to start streaming a buffer (single-cycle pulse)
- stream_buf  in  bufp_width  buffer to stream, sampled on accepted start
- stream_len  in  fieldp_width  index of the last field to stream, inclusive; sampled on accepted start
- pat_bit  out  1  serial pattern bit
- pat_valid  out  1  pat_bit is valid
- pat_ready  in  1  downstream accepts pat_bit
- stream_busy  out  1  streamer is active
- stream_done  out  1  one-cycle pulse when the last bit has been accepted

Behaviour:
- Storage:
  - Array mem[buffer][field], buffer_width bits per entry.
  - Contents are not reset, except as described under Optional Feature.
- Core write:
  - When field_we=1, mem[bufp][fieldwp] <= field_byte_out at posedge.
- Core read:
  - Every cycle, field_byte_in <= mem[bufp][fieldp]; latency is 1 cycle.
  - Read-first: a read and write to the same address in the same cycle returns the old data. The new data is visible on the next read.
- Reset values: field_byte_in=0, pat_bit=0, pat_valid=0, stream_busy=0, stream_done=0. Streamer returns to IDLE, and all counters and latches are cleared to 0.
- Streamer FSM, states IDLE, FETCH, SHIFT:
  - IDLE:
    - stream_start=1 latches sbuf=stream_buf, slen=stream_len, fcnt=0, then goes to FETCH.
    - stream_busy=0 in IDLE only.
  - FETCH (1 cycle):
    - shreg <= mem[sbuf][fcnt] (read-first against a same-cycle core write), bcnt <= buffer_width-1, then goes to SHIFT.
    - pat_valid=0 during FETCH.
  - SHIFT:
    - pat_valid=1 and pat_bit=shreg MSB.
    - On pat_valid && pat_ready:
      - if bcnt!=0: shift left by one and decrement bcnt;
      - else if fcnt==slen: go to IDLE and pulse stream_done=1 in the following cycle;
      - else increment fcnt and go to FETCH.
    - Without pat_ready, pat_bit and pat_valid hold unchanged.
- Throughput: buffer_width bits per field plus one FETCH bubble per field.
  - Total cycles from start to done pulse with pat_ready tied high = 1 + (slen+1)*(buffer_width+1).
- stream_start while stream_busy=1 is ignored; the latched parameters are unchanged.
- slen=0 streams exactly one field. slen=2^fieldp_width-1 streams the whole buffer, and fcnt never wraps.
- Core writes to sbuf during streaming are legal:
  - a field written before its FETCH cycle edge streams the new value;
  - a field written on or after that edge streams the old value.
- Reset mid-stream: aborts immediately with no stream_done pulse; the next cycle is in IDLE with pat_valid=0.
- stream_done and stream_busy never assert in the same cycle.

Optional Feature:
- Macro: PATBUF_CLEAR_EN.
- When defined:
  - Reset enters an extra state CLEAR (instead of IDLE) after rst deasserts.
  - CLEAR writes 0 to one entry per cycle, sweeping all 2^(bufp_width+fieldp_width) entries in address order, then goes to IDLE.
  - stream_busy=1 during CLEAR.
  - Core writes and stream_start are ignored during CLEAR.
  - Core reads return 0 during CLEAR.
  - A rst during CLEAR restarts the sweep from address 0.
- When not defined: no CLEAR state; memory contents are undefined after reset; IDLE follows reset directly.

Test Plan:
- Write/read: write 0xA5 to buf 2 field 7, next cycle read bufp=2 fieldp=7 -> field_byte_in=0xA5 one cycle later.
- Read-during-write: buf1 f3=0x11, same-cycle write 0x22 and read of b1 f3 -> returns 0x11, then 0x22 on the following read.
- Stream: buf0 f0=0xC3, f1=0x0F, stream_len=1, pat_ready=1 -> bits 1,1,0,0,0,0,1,1,0,0,0,0,1,1,1,1; stream_done pulses 19 cycles after start; one pat_valid=0 gap between the bytes.
- Backpressure and ignored start: pat_ready low for 5 cycles mid-byte -> pat_bit holds; a second stream_start while busy has no effect; the sequence completes correctly.
- Reset mid-stream: assert rst during bit 3 of field 0 -> next cycle pat_valid=0, stream_busy=0, no stream_done; a new start then streams from field 0.
- PATBUF_CLEAR_EN: preload 0xFF everywhere, pulse rst -> stream_busy high for 256 cycles, then every field reads 0x00; a write issued during the sweep is lost.

Source files
------------

// File: rtl/pattern_buffer.sv
// rtl/pattern_buffer.sv - buffer/field store with serial pattern streamer; optional PATBUF_CLEAR_EN clears memory after reset
module pattern_buffer #(
   parameter int bufp_width   = 3,
   parameter int fieldp_width = 5,
   parameter int buffer_width = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [bufp_width-1:0]   bufp,
   input  logic [fieldp_width-1:0] fieldp,
   input  logic [fieldp_width-1:0] fieldwp,
   input  logic                    field_we,
   input  logic [buffer_width-1:0] field_byte_out,
   output logic [buffer_width-1:0] field_byte_in,
   input  logic                    stream_start,
   input  logic [bufp_width-1:0]   stream_buf,
   input  logic [fieldp_width-1:0] stream_len,
   output logic                    pat_bit,
   output logic                    pat_valid,
   input  logic                    pat_ready,
   output logic                    stream_busy,
   output logic                    stream_done
);

   localparam int addr_width = bufp_width + fieldp_width;
   localparam int depth      = 1 << addr_width;
   localparam int bcnt_width = (buffer_width > 1) ? $clog2(buffer_width) : 1;

`ifdef PATBUF_CLEAR_EN
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, CLEAR} state_t;
   localparam state_t reset_state = CLEAR;
   logic [addr_width-1:0] clr_addr;
`else
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;
   localparam state_t reset_state = IDLE;
`endif

   state_t state, next_state;

   logic [buffer_width-1:0] mem [depth];
   logic [bufp_width-1:0]   sbuf;
   logic [fieldp_width-1:0] slen;
   logic [fieldp_width-1:0] fcnt;
   logic [bcnt_width-1:0]   bcnt;
   logic [buffer_width-1:0] shreg;
   logic                    done_q;

   logic                    wr_en;
   logic [addr_width-1:0]   wr_addr;
   logic [buffer_width-1:0] wr_data;
   logic                    rd_zero;
   logic                    last_bit;
   logic                    last_field;

   assign last_bit    = (bcnt == '0);
   assign last_field  = (fcnt == slen);
   assign pat_bit     = (state == SHIFT) & shreg[buffer_width-1];
   assign stream_done = done_q;

   // Streamer state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= reset_state;
      else
         state <= next_state;
   end

   // Streamer next-state and handshake outputs
   always_comb begin
      next_state  = state;
      stream_busy = (state != IDLE);
      pat_valid   = (state == SHIFT);
      case (state)
         IDLE:    if (stream_start) next_state = FETCH;
         FETCH:   next_state = SHIFT;
         SHIFT:   if (pat_ready && last_bit) next_state = last_field ? IDLE : FETCH;
`ifdef PATBUF_CLEAR_EN
         CLEAR:   if (clr_addr == addr_width'(depth - 1)) next_state = IDLE;
`endif
         default: next_state = IDLE;
      endcase
   end

   // Write port mux: the clear sweep takes over the write port and blanks reads
   always_comb begin
      wr_en   = field_we;
      wr_addr = {bufp, fieldwp};
      wr_data = field_byte_out;
      rd_zero = 1'b0;
`ifdef PATBUF_CLEAR_EN
      if (state == CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = '0;
         rd_zero = 1'b1;
      end
`endif
   end

   // Storage array write; contents intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Core read port, one cycle latency, read-first against a same-cycle write
   always_ff @(posedge clk) begin
      if (rst)
         field_byte_in <= '0;
      else if (rd_zero)
         field_byte_in <= '0;
      else
         field_byte_in <= mem[{bufp, fieldp}];
   end

   // Streamer datapath: latched parameters, field/bit counters, shift register, done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         sbuf   <= '0;
         slen   <= '0;
         fcnt   <= '0;
         bcnt   <= '0;
         shreg  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (stream_start) begin
                  sbuf <= stream_buf;
                  slen <= stream_len;
                  fcnt <= '0;
               end
            end
            FETCH: begin
               shreg <= mem[{sbuf, fcnt}];
               bcnt  <= bcnt_width'(buffer_width - 1);
            end
            SHIFT: begin
               if (pat_ready) begin
                  if (!last_bit) begin
                     shreg <= {shreg[buffer_width-2:0], 1'b0};
                     bcnt  <= bcnt - 1'b1;
                  end else if (last_field) begin
                     done_q <= 1'b1;
                  end else begin
                     fcnt <= fcnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PATBUF_CLEAR_EN
   // Clear sweep address, restarts at 0 on every reset
   always_ff @(posedge clk) begin
      if (rst)
         clr_addr <= '0;
      else if (state == CLEAR)
         clr_addr <= clr_addr + 1'b1;
   end
`endif

endmodule

// File: tb/tb_pattern_buffer.sv
// tb/tb_pattern_buffer.sv - self-checking bench for pattern_buffer against a byte-array reference model
module tb_pattern_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] bufp;
   logic [4:0] fieldp;
   logic [4:0] fieldwp;
   logic       field_we;
   logic [7:0] field_byte_out;
   logic [7:0] field_byte_in;
   logic       stream_start;
   logic [2:0] stream_buf;
   logic [4:0] stream_len;
   logic       pat_bit;
   logic       pat_valid;
   logic       pat_ready;
   logic       stream_busy;
   logic       stream_done;

   int checks = 0;
   int errors = 0;
   logic [7:0] model_mem [0:255];

`ifdef PATBUF_CLEAR_EN
   localparam bit clr_build = 1'b1;
`else
   localparam bit clr_build = 1'b0;
`endif

   pattern_buffer #(.bufp_width(3), .fieldp_width(5), .buffer_width(8)) dut (
      .clk(clk), .rst(rst), .bufp(bufp), .fieldp(fieldp), .fieldwp(fieldwp),
      .field_we(field_we), .field_byte_out(field_byte_out), .field_byte_in(field_byte_in),
      .stream_start(stream_start), .stream_buf(stream_buf), .stream_len(stream_len),
      .pat_bit(pat_bit), .pat_valid(pat_valid), .pat_ready(pat_ready),
      .stream_busy(stream_busy), .stream_done(stream_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic core_write(input int b, input int f, input logic [7:0] d);
      bufp = 3'(b); fieldwp = 5'(f); field_byte_out = d; field_we = 1'b1;
      tick();
      field_we = 1'b0;
      model_mem[b*32+f] = d;
   endtask

   task automatic read_check(input string tag, input int b, input int f);
      bufp = 3'(b); fieldp = 5'(f);
      tick();
      check(tag, 32'(field_byte_in), 32'(model_mem[b*32+f]));
   endtask

   task automatic zero_model();
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
   endtask

`ifdef PATBUF_CLEAR_EN
   task automatic wait_sweep(input string tag);
      int n = 0;
      while (stream_busy && n < 1000) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'd256);
      zero_model();
   endtask
`endif

   // mode 0: ready high, 1: random ready, 2: ready low for cycles 5..9
   task automatic run_stream(input string tag, input int b, input int len, input int mode,
                             input bit inj_start, input bit inj_write);
      logic [7:0] exp_bytes [$];
      bit got [$];
      int cyc, done_cyc;
      logic pv, pr, pb;
      logic [7:0] byte_v;
      for (int f = 0; f <= len; f++) exp_bytes.push_back(model_mem[b*32+f]);
      stream_buf = 3'(b); stream_len = 5'(len); stream_start = 1'b1; pat_ready = 1'b1;
      tick();
      stream_start = 1'b0;
      cyc = 1; done_cyc = -1; pv = 1'b0; pr = 1'b0; pb = 1'b0;
      while (cyc < 3000) begin
         case (mode)
            0: pat_ready = 1'b1;
            1: pat_ready = 1'($urandom_range(0, 1));
            default: pat_ready = !(cyc >= 5 && cyc < 10);
         endcase
         if (inj_start) begin
            stream_start = (cyc == 4);
            stream_buf = 3'(b + 1);
            stream_len = 5'd0;
         end
         if (inj_write) begin
            field_we = (cyc == 3 || cyc == 4 || cyc == 10);
            bufp = 3'(b);
            if (cyc == 3) begin
               fieldwp = 5'd2; field_byte_out = ~model_mem[b*32+2];
               model_mem[b*32+2] = field_byte_out; exp_bytes[2] = field_byte_out;
            end else if (cyc == 4) begin
               fieldwp = 5'd0; field_byte_out = ~model_mem[b*32];
               model_mem[b*32] = field_byte_out;
            end else if (cyc == 10) begin
               fieldwp = 5'd1; field_byte_out = ~model_mem[b*32+1];
               model_mem[b*32+1] = field_byte_out;
            end
         end
         if (pv && !pr) begin
            check({tag, "_hold_valid"}, 32'(pat_valid), 32'd1);
            check({tag, "_hold_bit"}, 32'(pat_bit), 32'(pb));
         end
         check({tag, "_done_busy_excl"}, 32'(stream_done & stream_busy), 32'd0);
         if (stream_done) begin
            done_cyc = cyc;
            break;
         end
         if (pat_valid && pat_ready) got.push_back(pat_bit);
         pv = pat_valid; pr = pat_ready; pb = pat_bit;
         tick();
         cyc++;
      end
      stream_start = 1'b0; field_we = 1'b0; pat_ready = 1'b1;
      check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
      if (mode != 1)
         check({tag, "_cycles"}, 32'(done_cyc), 32'(1 + (len + 1) * 9 + (mode == 2 ? 5 : 0)));
      check({tag, "_bit_count"}, 32'(got.size()), 32'((len + 1) * 8));
      for (int f = 0; f <= len; f++) begin
         byte_v = 8'h00;
         for (int k = 0; k < 8; k++)
            if (f*8 + k < got.size()) byte_v = {byte_v[6:0], got[f*8+k]};
         check($sformatf("%s_byte_f%0d", tag, f), 32'(byte_v), 32'(exp_bytes[f]));
      end
      tick();
      check({tag, "_done_one_cycle"}, 32'(stream_done), 32'd0);
   endtask

   initial begin
      int addrs [$];
      int nz;
      bit any_done;
      rst = 1'b1; bufp = '0; fieldp = '0; fieldwp = '0; field_we = 1'b0;
      field_byte_out = '0; stream_start = 1'b0; stream_buf = '0; stream_len = '0; pat_ready = 1'b1;
      tick(); tick();
      check("rst_field_byte_in", 32'(field_byte_in), 32'd0);
      check("rst_pat_bit", 32'(pat_bit), 32'd0);
      check("rst_pat_valid", 32'(pat_valid), 32'd0);
      check("rst_stream_done", 32'(stream_done), 32'd0);
      check("rst_stream_busy", 32'(stream_busy), 32'(clr_build));
      rst = 1'b0;
`ifdef PATBUF_CLEAR_EN
      wait_sweep("init_sweep_len");
`else
      tick();
`endif

      core_write(2, 7, 8'hA5);
      read_check("wr_rd_a5", 2, 7);

      core_write(1, 3, 8'h11);
      bufp = 3'd1; fieldp = 5'd3; fieldwp = 5'd3; field_byte_out = 8'h22; field_we = 1'b1;
      tick();
      field_we = 1'b0;
      check("rdw_old", 32'(field_byte_in), 32'h11);
      tick();
      check("rdw_new", 32'(field_byte_in), 32'h22);
      model_mem[1*32+3] = 8'h22;

      for (int i = 0; i < 10; i++) begin
         int a = $urandom_range(0, 255);
         core_write(a / 32, a % 32, 8'($urandom_range(0, 255)));
         addrs.push_back(a);
      end
      for (int i = 0; i < 10; i++)
         read_check($sformatf("rand_rd_%0d", i), addrs[i] / 32, addrs[i] % 32);

      core_write(0, 0, 8'hC3);
      core_write(0, 1, 8'h0F);
      run_stream("plan_stream", 0, 1, 0, 1'b0, 1'b0);

      for (int f = 0; f < 3; f++) core_write(4, f, 8'($urandom_range(0, 255)));
      run_stream("backpressure", 4, 2, 2, 1'b1, 1'b0);

      for (int f = 0; f < 32; f++) core_write(5, f, 8'($urandom_range(0, 255)));
      run_stream("rand_ready_full", 5, 31, 1, 1'b0, 1'b0);

      core_write(6, 0, 8'($urandom_range(0, 255)));
      core_write(6, 1, 8'($urandom_range(0, 255)));
      run_stream("slen0", 6, 0, 0, 1'b0, 1'b0);

      for (int f = 0; f < 4; f++) core_write(3, f, 8'($urandom_range(0, 255)));
      run_stream("wr_during", 3, 3, 0, 1'b0, 1'b1);
      read_check("wr_during_rd_f0", 3, 0);
      read_check("wr_during_rd_f1", 3, 1);

      core_write(1, 0, 8'($urandom_range(0, 255)));
      core_write(1, 1, 8'($urandom_range(0, 255)));
      stream_buf = 3'd1; stream_len = 5'd1; stream_start = 1'b1; pat_ready = 1'b1;
      tick();
      stream_start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_pat_valid", 32'(pat_valid), 32'd0);
      check("midrst_done", 32'(stream_done), 32'd0);
      check("midrst_busy", 32'(stream_busy), 32'(clr_build));
`ifdef PATBUF_CLEAR_EN
      wait_sweep("midrst_sweep_len");
`endif
      any_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (stream_done) any_done = 1'b1;
         tick();
      end
      check("midrst_no_done", 32'(any_done), 32'd0);
      run_stream("after_rst", 1, 1, 0, 1'b0, 1'b0);

`ifdef PATBUF_CLEAR_EN
      for (int a = 0; a < 256; a++) core_write(a / 32, a % 32, 8'hFF);
      bufp = 3'd7; fieldp = 5'd31;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      begin
         int n = 0;
         nz = 0;
         while (stream_busy && n < 1000) begin
            if (field_byte_in !== 8'h00) nz++;
            field_we = (n == 100); bufp = 3'd0; fieldwp = 5'd0; field_byte_out = 8'h5A;
            stream_start = (n == 50); stream_buf = 3'd0; stream_len = 5'd0;
            tick();
            n++;
         end
         field_we = 1'b0; stream_start = 1'b0;
         check("clr_sweep_len", 32'(n), 32'd256);
         check("clr_read_zero_during", 32'(nz), 32'd0);
      end
      zero_model();
      check("clr_start_ignored_valid", 32'(pat_valid), 32'd0);
      tick();
      check("clr_start_ignored_busy", 32'(stream_busy), 32'd0);
      nz = 0;
      for (int a = 0; a < 256; a++) begin
         bufp = 3'(a / 32); fieldp = 5'(a % 32);
         tick();
         if (field_byte_in !== 8'h00) nz++;
      end
      check("clr_all_zero", 32'(nz), 32'd0);
      read_check("clr_write_lost", 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
